// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Memory end of the instruction-fetch interface. Fetch addresses arrive on a
//   valid/ready request channel and read a synchronous word-organised RAM.
//   Instruction, address and fault code leave through a 2-entry response
//   queue on a valid/ready channel. A flush discards everything in flight, and
//   a loader port writes the RAM at any time.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/ready/addr   fetch request channel (byte address)
//   rsp_valid/ready        response channel handshake (head of queue)
//   rsp_inst/addr/fault    head response; 0 when queue empty
//                          (fault 00 ok, 01 misaligned, 10 out of range)
//   flush                  redirect: drop in-flight and queued responses
//   ld_we/addr/data        loader write port (word index)
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_inst,
  output logic [31:0]                    rsp_addr,
  output logic [1:0]                     rsp_fault,
  input  logic                           flush,
  input  logic                           ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  // read stage
  logic        inflight;
  logic [31:0] if_addr;
  logic [1:0]  if_fault;
  logic [31:0] rd_data;

  // 2-entry response queue
  logic [31:0] q_inst  [2];
  logic [31:0] q_addr  [2];
  logic [1:0]  q_fault [2];
  logic        q_head;
  logic        q_tail;
  logic [1:0]  q_count;

  logic [31:0] offset;
  logic [1:0]  req_fault;
  logic [1:0]  occ;
  logic        pop;
  logic        accept;
  logic [31:0] push_inst;

  // Address classification; misaligned takes priority over range.
  always_comb begin
    offset    = req_addr - BASE_ADDR;
    req_fault = 2'b00;
    if (req_addr[1:0] != 2'b00)
      req_fault = 2'b01;
    else if ((req_addr < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH_WORDS))
      req_fault = 2'b10;
  end

  always_comb begin
    rsp_valid = !rst && (q_count != 2'd0);
    rsp_inst  = '0;
    rsp_addr  = '0;
    rsp_fault = '0;
    if (rsp_valid) begin
      rsp_inst  = q_inst[q_head];
      rsp_addr  = q_addr[q_head];
      rsp_fault = q_fault[q_head];
    end
  end

  // Credit: in-flight read counts against queue space, so a capture always
  // finds a free slot; a same-cycle pop frees one.
  always_comb begin
    pop       = rsp_valid && rsp_ready;
    occ       = q_count + {1'b0, inflight};
    req_ready = !rst && !flush && ((occ < 2'd2) || pop);
    accept    = req_valid && req_ready;
    push_inst = (if_fault != 2'b00) ? NOP_INST : rd_data;
  end

  // RAM: read and write share an edge, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_addr] <= ld_data;
    if (accept)
      rd_data <= mem[offset[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight <= 1'b0;
      q_head   <= 1'b0;
      q_tail   <= 1'b0;
      q_count  <= '0;
      if (rst) begin
        if_addr  <= '0;
        if_fault <= '0;
        for (int unsigned i = 0; i < 2; i++) begin
          q_inst[i]  <= '0;
          q_addr[i]  <= '0;
          q_fault[i] <= '0;
        end
      end
    end else begin
      inflight <= accept;
      if (accept) begin
        if_addr  <= req_addr;
        if_fault <= req_fault;
      end
      if (inflight) begin
        q_inst[q_tail]  <= push_inst;
        q_addr[q_tail]  <= if_addr;
        q_fault[q_tail] <= if_fault;
        q_tail          <= ~q_tail;
      end
      if (pop)
        q_head <= ~q_head;
      q_count <= q_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-memory responder for the RISC-V core's fetch path: the memory end of the fetch interface whose initiator is the PC register. It accepts fetch addresses over a valid/ready request channel and reads a synchronous word-organised instruction RAM. It returns the instruction, its address and a fault code over a valid/ready response channel, through a 2-entry output queue. It flushes on a taken branch/jump redirect, and a loader port fills the RAM.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0 (word aligned).
- NOP_INST, 32'h0000_0013: instruction returned on a fault (addi x0,x0,0).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  fetch byte address (PC value).
- rsp_valid  output  1  response at queue head valid.
- rsp_ready  input  1  consumer accepts the head response.
- rsp_inst  output  32  instruction word.
- rsp_addr  output  32  byte address that produced rsp_inst.
- rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range.
- flush  input  1  redirect; discard all in-flight and queued responses.
- ld_we  input  1  loader write enable.
- ld_addr  input  log2(DEPTH_WORDS)  loader word index.
- ld_data  input  32  loader write data.

## Operation
- Accept: req_valid && req_ready at a rising edge. The RAM is read with word index (req_addr-BASE_ADDR)>>2. Address, fault and a read-stage valid bit (inflight) are registered.
- Fault classification at accept: req_addr[1:0]!=0 gives 01. Otherwise req_addr<BASE_ADDR or word index>=DEPTH_WORDS gives 10. Misaligned has priority. Faulted responses carry NOP_INST; the RAM data is ignored.
- Capture: at the next edge, inflight data/address/fault are pushed into the 2-entry queue unless a flush occurs that cycle.
- Pop: rsp_valid && rsp_ready at a rising edge removes the head. rsp_* always show the head; when the queue is empty they are 0.
- Credit rule: let occ = queue_count + inflight and pop = rsp_valid && rsp_ready. Then req_ready = !rst && !flush && (occ<2 || pop). occ never exceeds 2. The combinational path rsp_ready to req_ready is permitted.
- Flush: at an edge with flush=1, the queue is emptied and inflight is cleared. A request on that cycle is not accepted, and a pop on that cycle is void. The consumer refetches from the redirected PC.
- Ordering: responses are returned strictly in acceptance order; nothing is dropped except by flush or rst.
- Loader: ld_we writes ld_data at ld_addr on the edge. A same-edge fetch read of the same word returns the old data. Loading is legal at any time and never affects queued responses.
- Priority per edge: rst > flush > push/pop/accept.

## Timing
- Reset: queue empty, inflight=0. rsp_valid=0, rsp_inst=0, rsp_addr=0, rsp_fault=00. req_ready=0 while rst=1 and 1 in the first cycle after. RAM contents are not reset.
- Latency: request accepted at edge E gives rsp_valid=1 in the cycle after edge E+1 (1-cycle RAM read plus queue capture).
- Throughput: with rsp_ready held high, one request is accepted and one response popped every cycle.
- Backpressure: with rsp_ready=0, at most 2 requests are outstanding; req_ready then stays 0 until a pop.
- Flush at edge F: rsp_valid=0 and req_ready=1 in the cycle after F. The earliest new response follows 2 edges after the next accept.
- Reset mid-operation behaves the same as flush and also clears outputs; loader writes in the reset cycle still take effect.

## Test plan
- Preload words 0..3 with 32'h11111111..44444444. Stream addresses 0,4,8,C with rsp_ready=1. Required: responses in order, first rsp_valid 2 edges after first accept, then one per cycle, all faults 00.
- Set rsp_ready=0 and request 0,4,8. Required: exactly 2 accepted, req_ready=0 on the third. Raise rsp_ready: 11111111 then 22222222 pop, then the 8 request is accepted.
- Request 0x6 and DEPTH_WORDS*4. Required: fault 01 and 10 respectively, rsp_inst=32'h00000013, rsp_addr echoed.
- With 2 responses queued, pulse flush together with a new request and rsp_ready=1. Required: the request is not accepted, rsp_valid=0 the next cycle, and a request 0xC afterwards returns 44444444 only.
- Loader writes 32'hDEADBEEF to word 1 on the same edge a fetch of address 4 is accepted. Required: the old 22222222 is returned; the next fetch of 4 returns DEADBEEF.
- Assert rst with 2 responses outstanding. Required: all outputs 0 and req_ready=0 during reset. After reset, nothing stale appears and RAM contents are preserved.
